// File: rtl/led_pwm_pkg.sv
// Shared types and helpers for the LED PWM dimmer: period/duty-width helpers and duty clamping.
package led_pwm_pkg;

    localparam int DEF_PWM_BITS = 3;
    localparam int DEF_PERIOD   = 32'sd1 << DEF_PWM_BITS;
    localparam int DEF_DUTY_W   = DEF_PWM_BITS + 32'sd1;

    typedef logic [DEF_DUTY_W-1:0] duty_t;

    function automatic int period_of(input int pwm_bits);
        return 32'sd1 << pwm_bits;
    endfunction

    function automatic int duty_width(input int pwm_bits);
        return pwm_bits + 32'sd1;
    endfunction

    // Saturates a requested duty at full scale (always on).
    function automatic logic [31:0] clamp_duty(input logic [31:0] duty, input logic [31:0] period);
        logic [31:0] res_s;
        if (duty > period) begin
            res_s = period;
        end else begin
            res_s = duty;
        end
        return res_s;
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One PWM channel: host target, active duty (jump or fade step) and the registered output.
// The fade step is compiled in with LED_DIMMER_FADE_EN; otherwise active loads target on update.
module led_pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int PWM_BITS     = 3,
    parameter int DEFAULT_DUTY = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                blink,
    input  logic                wr_en,
    input  logic [PWM_BITS:0]   wr_duty,
    input  logic                update,
    input  logic [PWM_BITS-1:0] ctr,
    output logic                pwm
);

    localparam int DUTY_W = duty_width(PWM_BITS);
    localparam logic [DUTY_W-1:0] RESET_DUTY =
        DUTY_W'(clamp_duty(32'(DEFAULT_DUTY), 32'(period_of(PWM_BITS))));

    logic [DUTY_W-1:0] target_r;
    logic [DUTY_W-1:0] active_r;
    logic [DUTY_W-1:0] active_next_s;
    logic              pwm_r;

    // Host-written target duty
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            target_r <= RESET_DUTY;
        end else if (wr_en) begin
            target_r <= wr_duty;
        end else begin
            target_r <= target_r;
        end
    end

    // Next active duty; reads the pre-write target so a same-cycle write waits one period
    always_comb begin
        active_next_s = active_r;
`ifdef LED_DIMMER_FADE_EN
        if (update && (active_r < target_r)) begin
            active_next_s = active_r + DUTY_W'(1);
        end else if (update && (active_r > target_r)) begin
            active_next_s = active_r - DUTY_W'(1);
        end else begin
            active_next_s = active_r;
        end
`else
        if (update) begin
            active_next_s = target_r;
        end else begin
            active_next_s = active_r;
        end
`endif
    end

    // Active duty register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_r <= RESET_DUTY;
        end else begin
            active_r <= active_next_s;
        end
    end

    // Gated output flop; duty is one bit wider than ctr so full scale is always on
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_r <= 1'b0;
        end else begin
            pwm_r <= blink && ({1'b0, ctr} < active_r);
        end
    end

    assign pwm = pwm_r;

endmodule

// File: rtl/led_pwm_dimmer.sv
// Multi-channel PWM dimmer: shared prescaler and period counter, per-channel duty via a write port.
// Define LED_DIMMER_FADE_EN to ramp active duty by one step every 2^FADE_BITS periods.
module led_pwm_dimmer
    import led_pwm_pkg::*;
#(
    parameter int CHANNELS      = 3,
    parameter int PWM_BITS      = 3,
    parameter int PRESCALE_BITS = 0,
    parameter int DEFAULT_DUTY  = 1,
    parameter int FADE_BITS     = 2
) (
    input  logic                                                  i_clk,
    input  logic                                                  i_rst_n,
    input  logic [CHANNELS-1:0]                                   i_blink,
    input  logic                                                  i_wr_valid,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0]    i_wr_chan,
    input  logic [PWM_BITS:0]                                     i_wr_duty,
    output logic                                                  o_wr_ready,
    output logic                                                  o_wr_err,
    output logic [CHANNELS-1:0]                                   o_pwm,
    output logic                                                  o_period_start
);

    localparam int PERIOD = period_of(PWM_BITS);
    localparam int DUTY_W = duty_width(PWM_BITS);

    logic                tick_s;
    logic                boundary_s;
    logic                update_s;
    logic                accept_s;
    logic                chan_ok_s;
    logic [DUTY_W-1:0]   wr_duty_s;
    logic [PWM_BITS-1:0] ctr_r;
    logic                ready_r;
    logic                err_r;
    logic                zero_first_r;
    logic                period_start_r;

    generate
        if (PRESCALE_BITS > 0) begin : g_prescale
            logic [PRESCALE_BITS-1:0] prescale_r;

            // Free-running prescaler; tick on all-ones
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    prescale_r <= {PRESCALE_BITS{1'b0}};
                end else begin
                    prescale_r <= prescale_r + PRESCALE_BITS'(1);
                end
            end

            assign tick_s = &prescale_r;
        end else begin : g_no_prescale
            assign tick_s = 1'b1;
        end
    endgenerate

    // Period counter, wraps naturally at 2^PWM_BITS
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ctr_r <= {PWM_BITS{1'b0}};
        end else if (tick_s) begin
            ctr_r <= ctr_r + PWM_BITS'(1);
        end else begin
            ctr_r <= ctr_r;
        end
    end

    assign boundary_s = tick_s && (&ctr_r);
    assign accept_s   = i_wr_valid && ready_r;
    assign chan_ok_s  = (32'(i_wr_chan) < 32'(CHANNELS));
    assign wr_duty_s  = DUTY_W'(clamp_duty(32'(i_wr_duty), 32'(PERIOD)));

`ifdef LED_DIMMER_FADE_EN
    generate
        if (FADE_BITS > 0) begin : g_fade_div
            logic [FADE_BITS-1:0] fade_div_r;

            // Period divider pacing the fade steps
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    fade_div_r <= {FADE_BITS{1'b0}};
                end else if (boundary_s) begin
                    fade_div_r <= fade_div_r + FADE_BITS'(1);
                end else begin
                    fade_div_r <= fade_div_r;
                end
            end

            assign update_s = boundary_s && (&fade_div_r);
        end else begin : g_fade_every
            assign update_s = boundary_s;
        end
    endgenerate
`else
    assign update_s = boundary_s;
`endif

    // Write handshake, error pulse and period-start alignment with the output flops
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ready_r        <= 1'b0;
            err_r          <= 1'b0;
            zero_first_r   <= 1'b1;
            period_start_r <= 1'b0;
        end else begin
            ready_r        <= 1'b1;
            err_r          <= accept_s && !chan_ok_s;
            zero_first_r   <= boundary_s;
            period_start_r <= zero_first_r;
        end
    end

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
            logic wr_en_s;

            assign wr_en_s = accept_s && chan_ok_s && (32'(i_wr_chan) == 32'(c));

            led_pwm_channel #(
                .PWM_BITS     (PWM_BITS),
                .DEFAULT_DUTY (DEFAULT_DUTY)
            ) u_channel (
                .clk     (i_clk),
                .rst_n   (i_rst_n),
                .blink   (i_blink[c]),
                .wr_en   (wr_en_s),
                .wr_duty (wr_duty_s),
                .update  (update_s),
                .ctr     (ctr_r),
                .pwm     (o_pwm[c])
            );
        end
    endgenerate

    assign o_wr_ready     = ready_r;
    assign o_wr_err       = err_r;
    assign o_period_start = period_start_r;

endmodule
